// File: rtl/fetch_align_buffer.sv
// Fetch/align buffer between the instruction memory and decode: word fetches in, whole instructions out.
// Optional compressed (16-bit) instruction support is enabled by defining TCORE_COMPRESSED_EN.
module fetch_align_buffer #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic [XLEN-1:0] flush_pc_i,
  output logic            req_valid_o,
  output logic [XLEN-1:0] req_addr_o,
  input  logic            req_ready_i,
  input  logic            rsp_valid_i,
  input  logic [31:0]     rsp_data_i,
  output logic            inst_valid_o,
  output logic [31:0]     inst_o,
  output logic [XLEN-1:0] inst_pc_o,
  output logic            inst_comp_o,
  input  logic            inst_ready_i
);

`ifdef TCORE_COMPRESSED_EN
  localparam logic ResetSkip = RESET_PC[1];
`else
  localparam logic ResetSkip = 1'b0;
`endif

  logic [15:0]     buf_q [4];
  logic [15:0]     buf_d [4];
  logic [1:0]      rd_ptr_q, rd_ptr_d;
  logic [1:0]      wr_ptr_q, wr_ptr_d;
  logic [2:0]      count_q, count_d;
  logic            outstanding_q, outstanding_d;
  logic            discard_q, discard_d;
  logic            skip_low_q, skip_low_d;
  logic [XLEN-1:0] fetch_addr_q, fetch_addr_d;
  logic [XLEN-1:0] pc_q, pc_d;

  logic [15:0]     h0, h1;
  logic            is_comp;
  logic [2:0]      need_cnt;
  logic [2:0]      push_cnt;
  logic            pop, push, req_fire;
  logic [XLEN-1:0] flush_word, flush_pc;
  logic            flush_skip;
  logic            unused_flush_bits;

  assign h0 = buf_q[rd_ptr_q];
  assign h1 = buf_q[rd_ptr_q + 2'd1];

`ifdef TCORE_COMPRESSED_EN
  assign is_comp    = (h0[1:0] != 2'b11);
  assign flush_pc   = {flush_pc_i[XLEN-1:1], 1'b0};
  assign flush_skip = flush_pc_i[1];
`else
  assign is_comp    = 1'b0;
  assign flush_pc   = {flush_pc_i[XLEN-1:2], 2'b00};
  assign flush_skip = 1'b0;
`endif

  assign flush_word        = {flush_pc_i[XLEN-1:2], 2'b00};
  assign unused_flush_bits = ^flush_pc_i[1:0];

  assign need_cnt = is_comp ? 3'd1 : 3'd2;
  assign push_cnt = skip_low_q ? 3'd1 : 3'd2;

  // Outputs are forced quiet while reset is held.
  assign req_valid_o  = rst_ni & ~outstanding_q & (count_q <= 3'd2) & ~flush_i;
  assign req_addr_o   = fetch_addr_q;
  assign inst_valid_o = rst_ni & (count_q >= need_cnt) & ~flush_i;
  assign inst_comp_o  = rst_ni & is_comp;
  assign inst_pc_o    = pc_q;

  always_comb begin
    inst_o = 32'h0;
    if (rst_ni) begin
      inst_o = is_comp ? {16'h0, h0} : {h1, h0};
    end
  end

  assign pop      = inst_valid_o & inst_ready_i;
  assign req_fire = req_valid_o & req_ready_i;
  assign push     = rsp_valid_i & ~discard_q & ~flush_i;

  always_comb begin
    buf_d         = buf_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    skip_low_d    = skip_low_q;
    fetch_addr_d  = fetch_addr_q;
    pc_d          = pc_q;

    if (flush_i) begin
      rd_ptr_d     = 2'd0;
      wr_ptr_d     = 2'd0;
      count_d      = 3'd0;
      fetch_addr_d = flush_word;
      pc_d         = flush_pc;
      skip_low_d   = flush_skip;
      // A response landing in the flush cycle retires the stale request outright.
      if (rsp_valid_i) begin
        outstanding_d = 1'b0;
        discard_d     = 1'b0;
      end else if (outstanding_q) begin
        discard_d = 1'b1;
      end
    end else begin
      if (rsp_valid_i) begin
        outstanding_d = 1'b0;
        discard_d     = 1'b0;
      end
      if (push) begin
        if (skip_low_q) begin
          buf_d[wr_ptr_q] = rsp_data_i[31:16];
          wr_ptr_d        = wr_ptr_q + 2'd1;
        end else begin
          buf_d[wr_ptr_q]        = rsp_data_i[15:0];
          buf_d[wr_ptr_q + 2'd1] = rsp_data_i[31:16];
          wr_ptr_d               = wr_ptr_q + 2'd2;
        end
        skip_low_d = 1'b0;
      end
      if (req_fire) begin
        outstanding_d = 1'b1;
        fetch_addr_d  = fetch_addr_q + XLEN'(4);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + need_cnt[1:0];
        pc_d     = pc_q + (is_comp ? XLEN'(2) : XLEN'(4));
      end
      count_d = count_q + (push ? push_cnt : 3'd0) - (pop ? need_cnt : 3'd0);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 4; i++) begin
        buf_q[i] <= 16'h0;
      end
      rd_ptr_q      <= 2'd0;
      wr_ptr_q      <= 2'd0;
      count_q       <= 3'd0;
      outstanding_q <= 1'b0;
      discard_q     <= 1'b0;
      skip_low_q    <= ResetSkip;
      fetch_addr_q  <= {RESET_PC[XLEN-1:2], 2'b00};
      pc_q          <= RESET_PC;
    end else begin
      buf_q         <= buf_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      skip_low_q    <= skip_low_d;
      fetch_addr_q  <= fetch_addr_d;
      pc_q          <= pc_d;
    end
  end

endmodule

// File: tb/tb_fetch_align_buffer.sv
// Directed self-checking bench for fetch_align_buffer; expectations follow TCORE_COMPRESSED_EN.
module tb_fetch_align_buffer;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic [31:0] flush_pc;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_comp;
  logic        inst_ready;

  fetch_align_buffer #(
    .XLEN     (32),
    .RESET_PC (32'h8000_0000)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .flush_i      (flush),
    .flush_pc_i   (flush_pc),
    .req_valid_o  (req_valid),
    .req_addr_o   (req_addr),
    .req_ready_i  (req_ready),
    .rsp_valid_i  (rsp_valid),
    .rsp_data_i   (rsp_data),
    .inst_valid_o (inst_valid),
    .inst_o       (inst),
    .inst_pc_o    (inst_pc),
    .inst_comp_o  (inst_comp),
    .inst_ready_i (inst_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        comp;
  } xfer_t;

  xfer_t       xfer_q[$];
  logic [31:0] fire_q[$];
  logic        hold_rsp;
  int          n_checks;
  int          n_errors;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    case (a)
      32'h8000_0000: mem_rd = 32'h0000_0013;
      32'h8000_0004: mem_rd = 32'h0010_0093;
      32'h8000_0008: mem_rd = 32'h4505_4501;
      32'h8000_000C: mem_rd = 32'h0093_4501;
      32'h8000_0010: mem_rd = 32'h4505_0010;
      32'h8000_0100: mem_rd = 32'h4509_4505;
      32'h8000_0200: mem_rd = 32'h0020_0113;
      32'h8000_0204: mem_rd = 32'h0030_0193;
      32'h8000_0208: mem_rd = 32'h0040_0213;
      32'h8000_0300: mem_rd = 32'h0050_0293;
      default:       mem_rd = 32'h0000_0013;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic expect_xfer(input int idx, input logic [31:0] ei, input logic [31:0] ep,
                             input logic ec);
    check($sformatf("xfer%0d_present", idx), 32'(xfer_q.size() > idx), 32'd1);
    if (xfer_q.size() > idx) begin
      check($sformatf("xfer%0d_inst", idx), xfer_q[idx].inst, ei);
      check($sformatf("xfer%0d_pc", idx), xfer_q[idx].pc, ep);
      check($sformatf("xfer%0d_comp", idx), 32'(xfer_q[idx].comp), 32'(ec));
    end
  endtask

  task automatic expect_fire(input int idx, input logic [31:0] ea);
    check($sformatf("fire%0d_present", idx), 32'(fire_q.size() > idx), 32'd1);
    if (fire_q.size() > idx) begin
      check($sformatf("fire%0d_addr", idx), fire_q[idx], ea);
    end
  endtask

  // Called at posedge+2; holds flush for exactly one cycle.
  task automatic do_flush(input logic [31:0] pc);
    flush    = 1'b1;
    flush_pc = pc;
    xfer_q.delete();
    fire_q.delete();
    @(negedge clk);
    check("flush_inst_valid", 32'(inst_valid), 32'd0);
    check("flush_req_valid", 32'(req_valid), 32'd0);
    @(posedge clk);
    #2;
    flush = 1'b0;
  endtask

  // Memory: one-cycle response latency unless hold_rsp stalls it; also logs fires and transfers.
  initial begin
    logic        fire;
    logic [31:0] faddr;
    logic        pend;
    logic [31:0] paddr;
    rsp_valid = 1'b0;
    rsp_data  = 32'h0;
    pend      = 1'b0;
    paddr     = 32'h0;
    forever begin
      @(negedge clk);
      fire  = rst_n && req_valid && req_ready;
      faddr = req_addr;
      if (fire) fire_q.push_back(faddr);
      if (rst_n && inst_valid && inst_ready) xfer_q.push_back({inst, inst_pc, inst_comp});
      @(posedge clk);
      #1;
      rsp_valid = 1'b0;
      if (fire) begin
        pend  = 1'b1;
        paddr = faddr;
      end
      if (pend && !hold_rsp) begin
        rsp_valid = 1'b1;
        rsp_data  = mem_rd(paddr);
        pend      = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    logic found;
    n_checks   = 0;
    n_errors   = 0;
    rst_n      = 1'b0;
    flush      = 1'b1;
    flush_pc   = 32'h1234_5678;
    req_ready  = 1'b1;
    inst_ready = 1'b1;
    hold_rsp   = 1'b0;

    // Reset: outputs quiet, flush ignored.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_valid", 32'(req_valid), 32'd0);
    check("rst_inst_valid", 32'(inst_valid), 32'd0);
    check("rst_inst", inst, 32'd0);
    check("rst_inst_comp", 32'(inst_comp), 32'd0);
    @(posedge clk);
    #2;
    flush = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_req_valid", 32'(req_valid), 32'd1);
    check("post_rst_req_addr", req_addr, 32'h8000_0000);
    check("post_rst_pc", inst_pc, 32'h8000_0000);
    check("post_rst_inst_valid", 32'(inst_valid), 32'd0);

    // Straight-line program: 32-bit, packed compressed and straddling instructions.
    repeat (30) @(posedge clk);
    expect_fire(0, 32'h8000_0000);
    expect_fire(1, 32'h8000_0004);
    expect_xfer(0, 32'h0000_0013, 32'h8000_0000, 1'b0);
    expect_xfer(1, 32'h0010_0093, 32'h8000_0004, 1'b0);
`ifdef TCORE_COMPRESSED_EN
    expect_xfer(2, 32'h0000_4501, 32'h8000_0008, 1'b1);
    expect_xfer(3, 32'h0000_4505, 32'h8000_000A, 1'b1);
    expect_xfer(4, 32'h0000_4501, 32'h8000_000C, 1'b1);
    expect_xfer(5, 32'h0010_0093, 32'h8000_000E, 1'b0);
    expect_xfer(6, 32'h0000_4505, 32'h8000_0012, 1'b1);
    expect_xfer(7, 32'h0000_0013, 32'h8000_0014, 1'b0);
`else
    expect_xfer(2, 32'h4505_4501, 32'h8000_0008, 1'b0);
    expect_xfer(3, 32'h0093_4501, 32'h8000_000C, 1'b0);
    expect_xfer(4, 32'h4505_0010, 32'h8000_0010, 1'b0);
    expect_xfer(5, 32'h0000_0013, 32'h8000_0014, 1'b0);
`endif

    // Flush with a request in flight: stale response dropped, odd-halfword target.
    @(posedge clk);
    #2;
    hold_rsp = 1'b1;
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("t4_outstanding_blocks_req", 32'(req_valid), 32'd0);
    @(posedge clk);
    #2;
    do_flush(32'h8000_0102);
    hold_rsp = 1'b0;
    repeat (14) @(posedge clk);
    expect_fire(0, 32'h8000_0100);
`ifdef TCORE_COMPRESSED_EN
    expect_xfer(0, 32'h0000_4509, 32'h8000_0102, 1'b1);
`else
    expect_xfer(0, 32'h4509_4505, 32'h8000_0100, 1'b0);
`endif
    expect_xfer(1, 32'h0000_0013, 32'h8000_0104, 1'b0);

    // Decode stall with a full buffer, then drain.
    @(posedge clk);
    #2;
    inst_ready = 1'b0;
    do_flush(32'h8000_0200);
    repeat (10) @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("stall%0d_req_valid", i), 32'(req_valid), 32'd0);
      check($sformatf("stall%0d_inst_valid", i), 32'(inst_valid), 32'd1);
      check($sformatf("stall%0d_inst", i), inst, 32'h0020_0113);
      check($sformatf("stall%0d_pc", i), inst_pc, 32'h8000_0200);
    end
    @(posedge clk);
    #2;
    inst_ready = 1'b1;
    repeat (14) @(posedge clk);
    expect_xfer(0, 32'h0020_0113, 32'h8000_0200, 1'b0);
    expect_xfer(1, 32'h0030_0193, 32'h8000_0204, 1'b0);
    expect_xfer(2, 32'h0040_0213, 32'h8000_0208, 1'b0);
    expect_xfer(3, 32'h0000_0013, 32'h8000_020C, 1'b0);

    // Flush coinciding with a response and a valid instruction.
    @(posedge clk);
    #2;
    inst_ready = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(posedge clk);
      #2;
      if (rsp_valid && inst_valid) found = 1'b1;
    end
    check("t6_setup_found", 32'(found), 32'd1);
    inst_ready = 1'b1;
    hold_rsp   = 1'b1;
    do_flush(32'h8000_0300);
    @(negedge clk);
    check("t6_empty_after_flush", 32'(inst_valid), 32'd0);
    check("t6_req_after_flush", 32'(req_valid), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("t6_wait%0d_inst_valid", i), 32'(inst_valid), 32'd0);
    end
    check("t6_no_transfer", 32'(xfer_q.size()), 32'd0);
    expect_fire(0, 32'h8000_0300);
    @(posedge clk);
    #2;
    hold_rsp = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("t6_no_bypass", 32'(inst_valid), 32'd0);
    @(negedge clk);
    check("t6_valid_after_write", 32'(inst_valid), 32'd1);
    check("t6_inst", inst, 32'h0050_0293);
    check("t6_pc", inst_pc, 32'h8000_0300);
    check("t6_comp", 32'(inst_comp), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
